// File: rtl/riscv_dbg_pkg.sv
// Shared debug-path constants for the RISC-V top: dump-reader state codes and
// the data-memory access constants it drives.
package riscv_dbg_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam logic [2:0]  FUNCT3_LW  = 3'b010;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/dmem_dump_reader.sv
// Data-memory read-back engine: holds the CPU, walks a word range through the
// external address port and streams {address, word} beats on valid/ready.
module dmem_dump_reader
    import riscv_dbg_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             cpu_hold,
    output logic [31:0]      mem_addr,
    output logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]       r_state;
    logic [SET_W-1:0] r_settle;
    logic [CNT_W-1:0] r_rem;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_out_addr;
    logic [31:0]      r_out_data;
    logic             r_out_valid;
    logic             r_cpu_hold;
    logic             r_done;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_rem       <= '0;
            r_mem_addr  <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cpu_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Misalignment wins over a zero count, so err and done stay exclusive.
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            r_err <= 1'b1;
                        end else if (word_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_mem_addr <= base_addr;
                            r_rem      <= word_count;
                            r_cpu_hold <= 1'b1;
                            r_settle   <= SET_W'(SETTLE_CYCLES - 1);
                            r_state    <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_out_data  <= mem_rdata;
                    r_out_addr  <= r_mem_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_rem == CNT_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_mem_addr <= r_mem_addr + WORD_BYTES;
                            r_rem      <= r_rem - 1'b1;
                            r_state    <= ST_CAPTURE;
                        end
                    end
                end
                ST_FINISH: begin
                    r_cpu_hold <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_hold   = r_cpu_hold;
    assign mem_addr   = r_mem_addr;
    assign mem_funct3 = FUNCT3_LW;
    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign out_data   = r_out_data;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Self-checking bench for dmem_dump_reader: a behavioural memory plus an
// expected-beat queue checked every cycle, directed cases and random dumps.
module tb_dmem_dump_reader;

    localparam int CNT_W  = 16;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_count;
    logic             cpu_hold;
    logic [31:0]      mem_addr;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    dmem_dump_reader #(.CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .cpu_hold(cpu_hold), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          beats_seen = 0;
    logic [31:0] last_addr = '0;
    int          ready_mode = 0;
    logic        rnd_ready = 1'b1;
    logic        man_ready = 1'b1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hA1;
            32'h14:  return 32'hB2;
            32'h18:  return 32'hC3;
            default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign mem_rdata = memf(mem_addr);
    assign out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_ready : man_ready;

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("funct3", 32'(mem_funct3), 32'h2);
            check("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            check("err_done_excl", 32'(err & done), 32'h0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid), 32'h0);
                end else begin
                    check("beat_addr", out_addr, exp_q[0].a);
                    check("beat_data", out_data, exp_q[0].d);
                    check("mem_addr_held", mem_addr, exp_q[0].a);
                    if (out_ready) begin
                        last_addr = exp_q[0].a;
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] b, input logic [CNT_W-1:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_dump(input logic [31:0] b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            beat_t bt;
            bt.a = b + 32'(4 * i);
            bt.d = memf(bt.a);
            exp_q.push_back(bt);
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check("done_seen", 32'(done_cnt - d0), 32'h1);
        tick();
        check("done_one_cycle", 32'(done), 32'h0);
        check("idle_after_done", 32'(busy), 32'h0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        check(name, 32'(out_valid), 32'h1);
    endtask

    task automatic run_dump(input logic [31:0] b, input int unsigned n);
        int d0 = done_cnt;
        int bs0 = beats_seen;
        expect_dump(b, n);
        issue(b, CNT_W'(n));
        wait_done(d0, 40 + int'(n) * 40);
        check("beats_per_dump", 32'(beats_seen - bs0), n);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int d0, e0, bs0;
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        tick(3);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_hold", 32'(cpu_hold), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done_err", 32'({done, err}), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        reset = 1'b0;
        tick();

        // T1: three-word dump, ready high, latency pinned by literals
        d0 = done_cnt; bs0 = beats_seen;
        expect_dump(32'h10, 3);
        issue(32'h10, 16'd3);
        check("t1_hold_up", 32'(cpu_hold), 32'h1);
        tick(2);
        check("t1_valid_early", 32'(out_valid), 32'h0);
        tick();
        check("t1_first_valid", 32'(out_valid), 32'h1);
        check("t1_first_addr", out_addr, 32'h10);
        check("t1_first_data", out_data, 32'hA1);
        wait_done(d0, 40);
        check("t1_beats", 32'(beats_seen - bs0), 32'h3);
        check("t1_last_addr", last_addr, 32'h18);

        // T2: stall beat 2 for five cycles
        ready_mode = 2; man_ready = 1'b0;
        d0 = done_cnt; bs0 = beats_seen;
        expect_dump(32'h10, 3);
        issue(32'h10, 16'd3);
        wait_valid("t2_beat1_valid");
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        wait_valid("t2_beat2_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(out_valid), 32'h1);
            check("t2_hold_addr", out_addr, 32'h14);
            check("t2_hold_data", out_data, 32'hB2);
            check("t2_hold_mem_addr", mem_addr, 32'h14);
        end
        man_ready = 1'b1;
        wait_done(d0, 40);
        check("t2_beats", 32'(beats_seen - bs0), 32'h3);
        ready_mode = 0;

        // T3: misaligned start and zero-count start
        e0 = err_cnt;
        issue(32'h12, 16'd3);
        check("t3_err_pulse", 32'(err), 32'h1);
        check("t3_no_hold", 32'(cpu_hold), 32'h0);
        tick();
        check("t3_err_one_cycle", 32'(err), 32'h0);
        check("t3_still_no_hold", 32'(cpu_hold | busy), 32'h0);
        check("t3_err_count", 32'(err_cnt - e0), 32'h1);
        d0 = done_cnt;
        issue(32'h40, 16'd0);
        check("t3_zero_done", 32'(done), 32'h1);
        check("t3_zero_no_hold", 32'(cpu_hold | busy), 32'h0);
        tick(4);
        check("t3_zero_done_count", 32'(done_cnt - d0), 32'h1);

        // T4: address wrap
        run_dump(32'hFFFF_FFFC, 2);
        check("t4_wrap_addr", last_addr, 32'h0);

        // T5: reset during beat 2 of 4
        ready_mode = 2; man_ready = 1'b0;
        d0 = done_cnt;
        expect_dump(32'h80, 4);
        issue(32'h80, 16'd4);
        wait_valid("t5_beat1_valid");
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        wait_valid("t5_beat2_valid");
        reset = 1'b1;
        tick();
        check("t5_valid_cleared", 32'(out_valid), 32'h0);
        check("t5_hold_cleared", 32'(cpu_hold), 32'h0);
        check("t5_busy_cleared", 32'(busy), 32'h0);
        check("t5_out_addr_cleared", out_addr, 32'h0);
        check("t5_mem_addr_cleared", mem_addr, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        tick(3);
        check("t5_no_done", 32'(done_cnt - d0), 32'h0);
        ready_mode = 1;
        run_dump(32'h100, 4);

        // T6: start re-pulsed while busy is ignored
        ready_mode = 0;
        d0 = done_cnt; bs0 = beats_seen; e0 = err_cnt;
        expect_dump(32'h200, 5);
        issue(32'h200, 16'd5);
        tick(3);
        issue(32'h300, 16'd7);
        tick(2);
        issue(32'h301, 16'd2);
        wait_done(d0, 80);
        check("t6_beats", 32'(beats_seen - bs0), 32'h5);
        check("t6_no_err", 32'(err_cnt - e0), 32'h0);

        // Random dumps with random backpressure
        ready_mode = 1;
        for (int t = 0; t < 20; t++) begin
            int unsigned kind = $urandom_range(0, 9);
            logic [31:0] b = {$urandom(), 2'b00} ;
            if (kind == 0) begin
                e0 = err_cnt;
                issue(b | 32'($urandom_range(1, 3)), CNT_W'($urandom_range(1, 8)));
                check("rand_err", 32'(err), 32'h1);
                tick();
                check("rand_err_count", 32'(err_cnt - e0), 32'h1);
            end else if (kind == 1) begin
                issue(b, '0);
                check("rand_zero_done", 32'(done), 32'h1);
                tick();
            end else begin
                run_dump(b, $urandom_range(1, 8));
            end
            tick($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
